// File: rtl/npc_pkg.sv
// Shared widths and commit-FSM state encoding for the NPC core.
package npc_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef enum logic [1:0] {
    CS_RUN  = 2'd0,
    CS_HALT = 2'd1,
    CS_HANG = 2'd2
  } commit_state_t;

endpackage

// File: rtl/gpr_array.sv
// GPR storage with x0 hardwired to zero, two combinational read ports and a flat snapshot.
// Write lands at the clock edge; optional same-cycle write-to-read bypass under GPR_RD_BYPASS_EN.
module gpr_array
  import npc_pkg::*;
#(
  parameter int W = XLEN,
  parameter int N = NREG
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wen,
  input  logic [4:0]     waddr,
  input  logic [W-1:0]   wdata,
  input  logic [4:0]     raddr1,
  input  logic [4:0]     raddr2,
  output logic [W-1:0]   rdata1,
  output logic [W-1:0]   rdata2,
  output logic [N*W-1:0] rf_flat
);

  logic [W-1:0] regs [N];
  logic [W-1:0] stored1;
  logic [W-1:0] stored2;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) regs[k] <= '0;
    end else if (wen && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign stored1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign stored2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

`ifdef GPR_RD_BYPASS_EN
  assign rdata1 = (wen && waddr == raddr1 && raddr1 != 5'd0) ? wdata : stored1;
  assign rdata2 = (wen && waddr == raddr2 && raddr2 != 5'd0) ? wdata : stored2;
`else
  assign rdata1 = stored1;
  assign rdata2 = stored2;
`endif

  always_comb begin
    rf_flat = '0;
    for (int k = 1; k < N; k++) rf_flat[k*W +: W] = regs[k];
  end

endmodule

// File: rtl/gpr_commit.sv
// GPR file plus commit tracker: registered difftest pulse (1 cycle), retire counter, ebreak/watchdog stop.
// No backpressure; HALT/HANG ignore writes and commits until rst. Optional read bypass: GPR_RD_BYPASS_EN.
module gpr_commit
  import npc_pkg::*;
#(
  parameter int XLEN        = npc_pkg::XLEN,
  parameter int NREG        = npc_pkg::NREG,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [4:0]        waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic [XLEN-1:0]   commit_dnpc,
  input  logic              commit_ebreak,
  output logic [NREG*XLEN-1:0] rf_flat,
  output logic              diff_valid,
  output logic [XLEN-1:0]   diff_pc,
  output logic [XLEN-1:0]   diff_dnpc,
  output logic [63:0]       retire_cnt,
  output logic              halted,
  output logic              hang
);

  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES - 1);

  commit_state_t state, state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic run;
  logic wen_run;
  logic commit_run;

  assign run        = (state == CS_RUN);
  assign wen_run    = wen && run;
  assign commit_run = commit_valid && run;

  gpr_array #(.W(XLEN), .N(NREG)) u_gpr_array (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen_run),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .rf_flat (rf_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CS_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CS_RUN: begin
        if (commit_valid && commit_ebreak)         state_nxt = CS_HALT;
        else if (!commit_valid && wdog == WDOG_MAX) state_nxt = CS_HANG;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    halted = (state == CS_HALT);
    hang   = (state == CS_HANG);
  end

  // Outside RUN everything here holds; diff_valid drops because commit_run is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_valid <= 1'b0;
      diff_pc    <= '0;
      diff_dnpc  <= '0;
      retire_cnt <= '0;
      wdog       <= '0;
    end else begin
      diff_valid <= commit_run;
      if (commit_run) begin
        diff_pc    <= commit_pc;
        diff_dnpc  <= commit_dnpc;
        retire_cnt <= retire_cnt + 64'd1;
      end
      if (run) begin
        if (commit_valid)          wdog <= '0;
        else if (wdog != WDOG_MAX) wdog <= wdog + 1'b1;
      end
    end
  end

endmodule
